alu_nbit_pipelined: RTL and testbench



---
 rtl/alu_nbit_pipelined.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_nbit_pipelined.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_pipelined.sv
// alu_nbit_pipelined: registered WIDTH-bit ALU with valid/ready handshakes on
// both sides and a result accumulator that can stand in for operand A.
// Optional build macro ALU_MUL_EN adds an iterative shift-add multiplier on
// opcode 111 (one partial-product step per cycle). Without it, opcode 111
// produces a single err beat with y=0.
module alu_nbit_pipelined #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_GT  = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_eff;
  logic             accept;
  logic             fsm_idle;
  logic             load;

  // Single-cycle datapath results
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   shl_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_flag;
  logic             alu_err;

  // Value presented to the result register on a load
  logic [WIDTH-1:0] res_y;
  logic             res_flag;
  logic             res_err;

  assign op     = op_e'(opcode);
  assign a_eff  = acc_sel ? acc_q : a;
  assign shamt  = b[SHW-1:0];
  assign sum_w  = {1'b0, a_eff} + {1'b0, b};
  assign diff_w = {1'b0, a_eff} - {1'b0, b};
  // Shifting in a WIDTH+1 frame leaves the last bit shifted out in the MSB;
  // a zero shift leaves that MSB at 0.
  assign shl_w  = {1'b0, a_eff} << shamt;

  // Ready is withheld in reset, during a multiply, and while a result is held
  assign in_ready = rst_n && fsm_idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle operation decode
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves a value unassigned and infers a latch.
    alu_y    = '0;
    alu_flag = 1'b0;
    alu_err  = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_y    = sum_w[WIDTH-1:0];
        alu_flag = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_y    = diff_w[WIDTH-1:0];
        alu_flag = diff_w[WIDTH];
      end
      OP_GT: begin
        alu_flag = (a_eff > b);
        alu_y    = {WIDTH{alu_flag}};
      end
      OP_AND: begin
        alu_y    = a_eff & b;
        alu_flag = |alu_y;
      end
      OP_OR: begin
        alu_y    = a_eff | b;
        alu_flag = |alu_y;
      end
      OP_XOR: begin
        alu_y    = a_eff ^ b;
        alu_flag = (a_eff == b);
      end
      OP_SHL: begin
        alu_y    = shl_w[WIDTH-1:0];
        alu_flag = shl_w[WIDTH];
      end
      OP_MUL: begin
`ifndef ALU_MUL_EN
        alu_err  = 1'b1;
`endif
      end
      default: begin
        alu_err  = 1'b1;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e             state_q;
  state_e             state_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic               start_mul;
  logic               mul_done;

  assign start_mul = accept && (op == OP_MUL);
  assign mul_done  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  assign prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign fsm_idle  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign load      = (accept && (op != OP_MUL)) || mul_done;

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enter MUL on accept of opcode 111, leave on the last step
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add multiplier: latch operands on accept, one step per MUL cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_eff};
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nxt;
      cnt_q    <= cnt_q + SHW'(1);
    end
  end

  // Result source: the final multiplier step or the single-cycle decode
  always_comb begin
    if (mul_done) begin
      res_y    = prod_nxt[WIDTH-1:0];
      res_flag = |prod_nxt[2*WIDTH-1:WIDTH];
      res_err  = 1'b0;
    end else begin
      res_y    = alu_y;
      res_flag = alu_flag;
      res_err  = alu_err;
    end
  end
`else
  assign fsm_idle = 1'b1;
  assign busy     = 1'b0;
  assign load     = accept;
  assign res_y    = alu_y;
  assign res_flag = alu_flag;
  assign res_err  = alu_err;
`endif

  // Result register and accumulator: load on a new result, otherwise drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      flag      <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
      acc_q     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      y         <= res_y;
      flag      <= res_flag;
      zero      <= (res_y == '0);
      err       <= res_err;
      acc_q     <= res_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_nbit_pipelined.sv
// tb_alu_nbit_pipelined: directed self-checking bench for alu_nbit_pipelined
// at WIDTH=8. Covers reset, every single-cycle opcode, backpressure ordering,
// accumulator chaining, and opcode 111 in whichever build is compiled.
module tb_alu_nbit_pipelined;

  localparam int WIDTH = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] GT  = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic             acc_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             flag;
  logic             zero;
  logic             err;
  logic             busy;

  int total = 0;
  int bad   = 0;

  alu_nbit_pipelined #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag      (flag),
    .zero      (zero),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] op, input logic sel,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    in_valid = 1'b1;
    opcode   = op;
    acc_sel  = sel;
    a        = av;
    b        = bv;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [WIDTH-1:0] yv,
                            input logic fv, input logic zv, input logic ev);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".y"},     32'(y),         32'(yv));
    check({tag, ".flag"},  32'(flag),      32'(fv));
    check({tag, ".zero"},  32'(zero),      32'(zv));
    check({tag, ".err"},   32'(err),       32'(ev));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    opcode    = ADD;
    acc_sel   = 1'b0;
    a         = 8'h55;
    b         = 8'h11;
    out_ready = 1'b1;

    // Reset held two cycles with a beat offered
    tick();
    check("rst1.in_ready", 32'(in_ready), 32'd0);
    tick();
    check("rst2.out_valid", 32'(out_valid), 32'd0);
    check("rst2.y",         32'(y),         32'd0);
    check("rst2.in_ready",  32'(in_ready),  32'd0);
    check("rst2.busy",      32'(busy),      32'd0);
    check("rst2.err",       32'(err),       32'd0);
    rst_n = 1'b1;

    // Accumulator is zero after reset: acc + 0 = 0
    beat(ADD, 1'b1, 8'hAA, 8'h00);
    check("acc0.in_ready", 32'(in_ready), 32'd1);
    tick();
    expect_out("acc0", 8'h00, 1'b0, 1'b1, 1'b0);

    beat(ADD, 1'b0, 8'hF0, 8'h20); tick();
    expect_out("add_carry", 8'h10, 1'b1, 1'b0, 1'b0);
    beat(SUB, 1'b0, 8'h05, 8'h05); tick();
    expect_out("sub_eq", 8'h00, 1'b0, 1'b1, 1'b0);
    beat(SUB, 1'b0, 8'h03, 8'h05); tick();
    expect_out("sub_borrow", 8'hFE, 1'b1, 1'b0, 1'b0);
    beat(ADD, 1'b0, 8'hFF, 8'h01); tick();
    expect_out("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0);

    // Backpressure: first result held, later beats wait, then drain in order
    beat(AND, 1'b0, 8'hF0, 8'h3C); tick();
    expect_out("bp1", 8'h30, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    beat(OR, 1'b0, 8'h0F, 8'hA0);
    check("bp.stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp.hold_ready1", 32'(in_ready), 32'd0);
    expect_out("bp.hold1", 8'h30, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp.hold_ready2", 32'(in_ready), 32'd0);
    expect_out("bp.hold2", 8'h30, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    expect_out("bp2", 8'hAF, 1'b1, 1'b0, 1'b0);
    beat(XOR, 1'b0, 8'h5A, 8'h5A); tick();
    expect_out("bp3", 8'h00, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    check("bp.drained", 32'(out_valid), 32'd0);
    check("bp.idle_ready", 32'(in_ready), 32'd1);

    // Accumulator chain: 3+4=7, 7+10=17, 17<<2=68
    beat(ADD, 1'b0, 8'h03, 8'h04); tick();
    expect_out("chain1", 8'h07, 1'b0, 1'b0, 1'b0);
    beat(ADD, 1'b1, 8'hEE, 8'd10); tick();
    expect_out("chain2", 8'h11, 1'b0, 1'b0, 1'b0);
    beat(SHL, 1'b1, 8'hEE, 8'd2); tick();
    expect_out("chain3", 8'h44, 1'b0, 1'b0, 1'b0);

    // Shift and compare edges
    beat(SHL, 1'b0, 8'h81, 8'd1); tick();
    expect_out("shl_out1", 8'h02, 1'b1, 1'b0, 1'b0);
    beat(SHL, 1'b0, 8'h80, 8'd8); tick();
    expect_out("shl_zero_amt", 8'h80, 1'b0, 1'b0, 1'b0);
    beat(SHL, 1'b0, 8'hC3, 8'd7); tick();
    expect_out("shl_max", 8'h80, 1'b1, 1'b0, 1'b0);
    beat(SHL, 1'b0, 8'h01, 8'd7); tick();
    expect_out("shl_max_f0", 8'h80, 1'b0, 1'b0, 1'b0);
    beat(GT, 1'b0, 8'h7F, 8'h80); tick();
    expect_out("gt_false", 8'h00, 1'b0, 1'b1, 1'b0);
    beat(GT, 1'b0, 8'h80, 8'h7F); tick();
    expect_out("gt_true", 8'hFF, 1'b1, 1'b0, 1'b0);
    beat(OR, 1'b0, 8'h00, 8'h00); tick();
    expect_out("or_zero", 8'h00, 1'b0, 1'b1, 1'b0);
    beat(AND, 1'b0, 8'hF0, 8'h0F); tick();
    expect_out("and_zero", 8'h00, 1'b0, 1'b1, 1'b0);
    beat(XOR, 1'b0, 8'hF0, 8'h0F); tick();
    expect_out("xor_ne", 8'hFF, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

`ifdef ALU_MUL_EN
    // 0x10 * 0x11 = 0x110: busy for 8 cycles, result at latency 9
    beat(MUL, 1'b0, 8'h10, 8'h11);
    tick();
    in_valid = 1'b0;
    check("mul.busy0",  32'(busy),      32'd1);
    check("mul.ready0", 32'(in_ready),  32'd0);
    check("mul.valid0", 32'(out_valid), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check($sformatf("mul.busy%0d", i),  32'(busy),      32'd1);
      check($sformatf("mul.ready%0d", i), 32'(in_ready),  32'd0);
      check($sformatf("mul.valid%0d", i), 32'(out_valid), 32'd0);
    end
    tick();
    expect_out("mul", 8'h10, 1'b1, 1'b0, 1'b0);
    check("mul.busy_done",  32'(busy),     32'd0);
    check("mul.ready_done", 32'(in_ready), 32'd1);

    // Accumulator times 3: 0x10 * 3 = 0x30, no high bits
    beat(MUL, 1'b1, 8'hFF, 8'h03);
    tick();
    in_valid = 1'b0;
    repeat (WIDTH - 1) tick();
    check("mul_acc.pending", 32'(out_valid), 32'd0);
    tick();
    expect_out("mul_acc", 8'h30, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply discards it
    beat(MUL, 1'b0, 8'hFF, 8'hFF);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mulrst.busy",     32'(busy),      32'd0);
    check("mulrst.valid",    32'(out_valid), 32'd0);
    check("mulrst.in_ready", 32'(in_ready),  32'd1);
    repeat (WIDTH + 2) tick();
    check("mulrst.no_result", 32'(out_valid), 32'd0);
    beat(ADD, 1'b1, 8'h77, 8'h00); tick();
    expect_out("mulrst.acc", 8'h00, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
`else
    // Opcode 111 is illegal in this build: one err beat with y=0
    beat(MUL, 1'b0, 8'h10, 8'h11); tick();
    in_valid = 1'b0;
    expect_out("mul_illegal", 8'h00, 1'b0, 1'b1, 1'b1);
    check("mul_illegal.busy", 32'(busy), 32'd0);
    // err clears on the next load, and the err beat loaded acc with 0
    beat(ADD, 1'b1, 8'h99, 8'h05); tick();
    expect_out("err_clear", 8'h05, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
`endif
    tick();
    check("final.drained", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
